// File: rtl/mcs4_pkg.sv
// mcs4 -- shared types and constants for the MCS-4 system.
//
// Contents:
//   addr_t      : 12-bit ROM address as seen by the i4001 debug write port
//   ctl_op_t    : host command opcodes for mcs4_run_ctl
//   ctl_state_t : mcs4_run_ctl status / FSM state encoding
//   Cycle_clks  : clocks per i4004 machine cycle (one SYNC per cycle)
package mcs4;

  localparam int ADDR_W     = 12;
  localparam int LOAD_CNT_W = 10;
  localparam int Cycle_clks = 8;

  typedef logic [ADDR_W-1:0] addr_t;

  typedef enum logic [1:0] {
    OP_LOAD = 2'd0,
    OP_RUN  = 2'd1,
    OP_HALT = 2'd2,
    OP_STEP = 2'd3
  } ctl_op_t;

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_HALTED = 3'd1,
    ST_LOAD   = 3'd2,
    ST_RUN    = 3'd3,
    ST_DRAIN  = 3'd4
  } ctl_state_t;

endpackage

// File: rtl/mcs4_rom_loader.sv
// mcs4_rom_loader -- LOAD datapath of the run controller.
//
// Streams host image bytes into the i4001 ROM debug write port, one byte
// per clock. The FSM pulses 'start' to open a load; the loader reports the
// exit handshake on 'done' (combinational, same clock as the handshake).
//
// Ports:
//   clk, rst        : system clock, asynchronous active-low reset
//   start           : open a new load (clears counter and truncation flag)
//   done            : final byte of this load is being accepted
//   ld_valid/ready  : image byte handshake; ld_data byte, ld_last end marker
//   rom_addr/wdata  : registered ROM write address and data
//   rom_wen         : one-clock write strobe per accepted byte
//   load_cnt        : bytes written so far by the current/last load
//   load_trunc      : sticky, load filled ROM_BYTES without ld_last
module mcs4_rom_loader
  import mcs4::*;
#(
  parameter int ROM_BYTES = 512
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  done,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic [7:0]            ld_data,
  input  logic                  ld_last,
  output addr_t                 rom_addr,
  output logic [7:0]            rom_wdata,
  output logic                  rom_wen,
  output logic [LOAD_CNT_W-1:0] load_cnt,
  output logic                  load_trunc
);

  logic ld_fire;
  logic at_end;

  assign ld_fire = ld_valid && ld_ready;
  assign at_end  = (load_cnt == LOAD_CNT_W'(ROM_BYTES - 1));
  assign done    = ld_fire && (ld_last || at_end);

  // Byte counter, write register and truncation flag. The write strobe is
  // a single-clock pulse following each handshake; address and data hold
  // their last values between pulses. ld_ready closes in the clock after
  // the exit handshake, while that final byte's write pulse still goes out.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ld_ready   <= 1'b0;
      rom_addr   <= '0;
      rom_wdata  <= '0;
      rom_wen    <= 1'b0;
      load_cnt   <= '0;
      load_trunc <= 1'b0;
    end else begin
      rom_wen <= 1'b0;
      if (start) begin
        load_cnt   <= '0;
        load_trunc <= 1'b0;
        ld_ready   <= 1'b1;
      end else if (ld_fire) begin
        rom_wen   <= 1'b1;
        rom_addr  <= addr_t'(load_cnt);
        rom_wdata <= ld_data;
        load_cnt  <= load_cnt + LOAD_CNT_W'(1);
        if (ld_last || at_end) begin
          ld_ready   <= 1'b0;
          load_trunc <= at_end && !ld_last;
        end
      end
    end
  end

endmodule

// File: rtl/mcs4_run_ctl.sv
// mcs4_run_ctl -- run/load controller for the MCS-4 system.
//
// Sequences ROM/RAM/CPU resets, streams a host program image into the ROM
// debug write port (via mcs4_rom_loader) and gates the i4004 with a clock
// enable so the host can run, halt or single-step it on machine-cycle
// boundaries (SYNC).
//
// Ports:
//   clk, rst                  : system clock, asynchronous active-low reset
//   cmd_valid/ready, cmd_op   : host command handshake (LOAD/RUN/HALT/STEP)
//   ld_valid/ready, ld_data,
//   ld_last                   : image byte stream, accepted only in LOAD
//   rom_addr/wdata/wen        : ROM debug write port
//   rom_rst, ram_rst, cpu_rst : active-high subsystem resets
//   cpu_ce                    : i4004 clock enable
//   sync                      : i4004 SYNC, observed only while draining
//   state                     : controller state
//   load_cnt, load_trunc      : result of the last LOAD
//   cmd_err                   : sticky, non-HALT op issued while running
// All outputs are registered.
module mcs4_run_ctl
  import mcs4::*;
#(
  parameter int ROM_BYTES = 512,
  parameter int RST_CLKS  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  ctl_op_t               cmd_op,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic [7:0]            ld_data,
  input  logic                  ld_last,
  output addr_t                 rom_addr,
  output logic [7:0]            rom_wdata,
  output logic                  rom_wen,
  output logic                  rom_rst,
  output logic                  ram_rst,
  output logic                  cpu_rst,
  output logic                  cpu_ce,
  input  logic                  sync,
  output ctl_state_t            state,
  output logic [LOAD_CNT_W-1:0] load_cnt,
  output logic                  load_trunc,
  output logic                  cmd_err
);

  localparam int RST_CNT_W = (RST_CLKS > 1) ? $clog2(RST_CLKS) : 1;
  localparam logic [RST_CNT_W-1:0] RST_CNT_LAST = RST_CNT_W'(RST_CLKS - 1);

  ctl_state_t           state_q, state_n;
  logic [RST_CNT_W-1:0] rst_cnt_q, rst_cnt_n;
  logic                 cold_q, cold_n;
  logic                 step_q, step_n;
  logic                 cmd_err_n;
  logic                 cmd_fire;
  logic                 load_start;
  logic                 load_done;
  logic                 ram_pulse;

  assign cmd_fire = cmd_valid && cmd_ready;
  assign state    = state_q;

  // Next-state logic. 'cold' marks that the CPU must be held in reset
  // before it next runs (after power-up or a fresh image); it is cleared
  // when RUN or STEP is accepted. 'step' records that the current DRAIN
  // came from STEP rather than HALT.
  always_comb begin
    state_n    = state_q;
    rst_cnt_n  = rst_cnt_q;
    cold_n     = cold_q;
    step_n     = step_q;
    cmd_err_n  = cmd_err;
    load_start = 1'b0;
    ram_pulse  = 1'b0;
    case (state_q)
      ST_RESET: begin
        if (rst_cnt_q == RST_CNT_LAST) begin
          rst_cnt_n = '0;
          state_n   = ST_HALTED;
        end else begin
          rst_cnt_n = rst_cnt_q + RST_CNT_W'(1);
        end
      end
      ST_HALTED: begin
        if (cmd_fire) begin
          case (cmd_op)
            OP_LOAD: begin
              state_n    = ST_LOAD;
              load_start = 1'b1;
            end
            OP_RUN: begin
              state_n = ST_RUN;
              cold_n  = 1'b0;
              step_n  = 1'b0;
            end
            OP_STEP: begin
              state_n = ST_DRAIN;
              cold_n  = 1'b0;
              step_n  = 1'b1;
            end
            OP_HALT: begin
              state_n = ST_HALTED;
            end
          endcase
        end
      end
      ST_LOAD: begin
        if (load_done) begin
          state_n   = ST_HALTED;
          cold_n    = 1'b1;
          ram_pulse = 1'b1;
        end
      end
      ST_RUN: begin
        if (cmd_fire) begin
          if (cmd_op == OP_HALT) begin
            state_n = ST_DRAIN;
            step_n  = 1'b0;
          end else begin
            cmd_err_n = 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        // Stop only once SYNC marks the end of a machine cycle, so the CPU
        // is always frozen on a cycle boundary.
        if (sync) begin
          state_n = ST_HALTED;
          step_n  = 1'b0;
        end
      end
      default: begin
        state_n = ST_RESET;
      end
    endcase
  end

  // State register and registered outputs. The outputs are decoded from
  // the next state so they change in the same clock as 'state'.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_RESET;
      rst_cnt_q <= '0;
      cold_q    <= 1'b1;
      step_q    <= 1'b0;
      cmd_err   <= 1'b0;
      cmd_ready <= 1'b0;
      rom_rst   <= 1'b1;
      ram_rst   <= 1'b1;
      cpu_rst   <= 1'b1;
      cpu_ce    <= 1'b0;
    end else begin
      state_q   <= state_n;
      rst_cnt_q <= rst_cnt_n;
      cold_q    <= cold_n;
      step_q    <= step_n;
      cmd_err   <= cmd_err_n;
      cmd_ready <= (state_n == ST_HALTED) || (state_n == ST_RUN);
      rom_rst   <= (state_n == ST_RESET);
      ram_rst   <= (state_n == ST_RESET) || ram_pulse;
      cpu_rst   <= (state_n == ST_RESET) || cold_n;
      cpu_ce    <= (state_n == ST_RUN) || (state_n == ST_DRAIN);
    end
  end

  mcs4_rom_loader #(
    .ROM_BYTES (ROM_BYTES)
  ) u_loader (
    .clk        (clk),
    .rst        (rst),
    .start      (load_start),
    .done       (load_done),
    .ld_valid   (ld_valid),
    .ld_ready   (ld_ready),
    .ld_data    (ld_data),
    .ld_last    (ld_last),
    .rom_addr   (rom_addr),
    .rom_wdata  (rom_wdata),
    .rom_wen    (rom_wen),
    .load_cnt   (load_cnt),
    .load_trunc (load_trunc)
  );

endmodule

// File: tb/tb_mcs4_run_ctl.sv
// tb_mcs4_run_ctl -- directed bench for mcs4_run_ctl.
// A tiny i4004 phase model produces SYNC from cpu_ce/cpu_rst; a negedge
// monitor counts enabled clocks, SYNC pulses, RAM reset pulses and logs
// every ROM write.
module tb_mcs4_run_ctl;
  import mcs4::*;

  logic                  clk;
  logic                  rst;
  logic                  cmd_valid;
  logic                  cmd_ready;
  ctl_op_t               cmd_op;
  logic                  ld_valid;
  logic                  ld_ready;
  logic [7:0]            ld_data;
  logic                  ld_last;
  addr_t                 rom_addr;
  logic [7:0]            rom_wdata;
  logic                  rom_wen;
  logic                  rom_rst;
  logic                  ram_rst;
  logic                  cpu_rst;
  logic                  cpu_ce;
  logic                  sync;
  ctl_state_t            state;
  logic [LOAD_CNT_W-1:0] load_cnt;
  logic                  load_trunc;
  logic                  cmd_err;

  int check_count = 0;
  int pass_count  = 0;
  int ce_cnt      = 0;
  int sync_cnt    = 0;
  int ram_cnt     = 0;
  logic [11:0] wr_addr_q[$];
  logic [7:0]  wr_data_q[$];
  logic [2:0]  phase;
  logic [7:0]  short_img [3] = '{8'hD5, 8'h20, 8'h40};

  mcs4_run_ctl #(
    .ROM_BYTES (512),
    .RST_CLKS  (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .ld_valid   (ld_valid),
    .ld_ready   (ld_ready),
    .ld_data    (ld_data),
    .ld_last    (ld_last),
    .rom_addr   (rom_addr),
    .rom_wdata  (rom_wdata),
    .rom_wen    (rom_wen),
    .rom_rst    (rom_rst),
    .ram_rst    (ram_rst),
    .cpu_rst    (cpu_rst),
    .cpu_ce     (cpu_ce),
    .sync       (sync),
    .state      (state),
    .load_cnt   (load_cnt),
    .load_trunc (load_trunc),
    .cmd_err    (cmd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // i4004 machine-cycle phase: advances on enabled clocks, SYNC in phase 7.
  always @(posedge clk) begin
    if (cpu_rst) phase <= 3'd0;
    else if (cpu_ce) phase <= phase + 3'd1;
  end
  assign sync = (phase == 3'd7);

  // Observation of DUT outputs half a clock after each active edge.
  always @(negedge clk) begin
    if (cpu_ce === 1'b1) ce_cnt++;
    if (sync === 1'b1) sync_cnt++;
    if (ram_rst === 1'b1) ram_cnt++;
    if (rom_wen === 1'b1) begin
      wr_addr_q.push_back(rom_addr);
      wr_data_q.push_back(rom_wdata);
    end
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_count++;
    if (got === exp) pass_count++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Present one command from a negedge and hold it until accepted; returns
  // at the negedge following the accepting clock.
  task automatic applyStimulus(input ctl_op_t op);
    int waited;
    waited    = 0;
    cmd_op    = op;
    cmd_valid = 1'b1;
    while (cmd_ready !== 1'b1 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 40) checkOutput("cmd_accept_timeout", 32'(waited), 32'd0);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Wait (bounded) for HALTED; reports clocks waited and the SYNC value
  // seen on the last observation before HALTED appeared.
  task automatic waitHalted(input string tag, output int lat, output logic last_sync);
    lat       = 0;
    last_sync = 1'b0;
    while (state !== ST_HALTED && lat < 20) begin
      last_sync = sync;
      @(negedge clk);
      lat++;
    end
    if (state !== ST_HALTED) checkOutput(tag, 32'(state), 32'(ST_HALTED));
  endtask

  initial begin
    int   wr_base;
    int   ram_base;
    int   ce_base;
    int   sync_base;
    int   sent;
    int   errs;
    int   lat;
    logic last_sync;

    rst       = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = OP_HALT;
    ld_valid  = 1'b0;
    ld_data   = 8'h00;
    ld_last   = 1'b0;

    // Reset values
    repeat (2) @(negedge clk);
    checkOutput("rst_state",     32'(state),      32'(ST_RESET));
    checkOutput("rst_rom_rst",   32'(rom_rst),    32'd1);
    checkOutput("rst_ram_rst",   32'(ram_rst),    32'd1);
    checkOutput("rst_cpu_rst",   32'(cpu_rst),    32'd1);
    checkOutput("rst_cpu_ce",    32'(cpu_ce),     32'd0);
    checkOutput("rst_rom_wen",   32'(rom_wen),    32'd0);
    checkOutput("rst_rom_addr",  32'(rom_addr),   32'd0);
    checkOutput("rst_cmd_ready", 32'(cmd_ready),  32'd0);
    checkOutput("rst_ld_ready",  32'(ld_ready),   32'd0);
    checkOutput("rst_load_cnt",  32'(load_cnt),   32'd0);
    checkOutput("rst_trunc",     32'(load_trunc), 32'd0);
    checkOutput("rst_cmd_err",   32'(cmd_err),    32'd0);

    // Reset release: RESET for 4 clocks, then HALTED and cold
    rst = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      checkOutput($sformatf("rel_state_%0d", i), 32'(state), 32'(ST_RESET));
    end
    @(negedge clk);
    checkOutput("rel_halted",    32'(state),     32'(ST_HALTED));
    checkOutput("rel_rom_rst",   32'(rom_rst),   32'd0);
    checkOutput("rel_ram_rst",   32'(ram_rst),   32'd0);
    checkOutput("rel_cpu_rst",   32'(cpu_rst),   32'd1);
    checkOutput("rel_cpu_ce",    32'(cpu_ce),    32'd0);
    checkOutput("rel_cmd_ready", 32'(cmd_ready), 32'd1);

    // Short load: D5 20 40, ld_last on the third
    ram_base = ram_cnt;
    wr_base  = wr_addr_q.size();
    applyStimulus(OP_LOAD);
    checkOutput("sl_state",     32'(state),     32'(ST_LOAD));
    checkOutput("sl_ld_ready",  32'(ld_ready),  32'd1);
    checkOutput("sl_cmd_ready", 32'(cmd_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      ld_valid = 1'b1;
      ld_data  = short_img[i];
      ld_last  = (i == 2);
      @(negedge clk);
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    checkOutput("sl_exit_ld_ready", 32'(ld_ready), 32'd0);
    checkOutput("sl_exit_wen",      32'(rom_wen),  32'd1);
    checkOutput("sl_exit_state",    32'(state),    32'(ST_HALTED));
    checkOutput("sl_exit_ram_rst",  32'(ram_rst),  32'd1);
    repeat (2) @(negedge clk);
    checkOutput("sl_wr_count", 32'(wr_addr_q.size() - wr_base), 32'd3);
    for (int i = 0; i < 3; i++) begin
      if (wr_addr_q.size() > wr_base + i) begin
        checkOutput($sformatf("sl_addr_%0d", i), 32'(wr_addr_q[wr_base+i]), 32'(i));
        checkOutput($sformatf("sl_data_%0d", i), 32'(wr_data_q[wr_base+i]), 32'(short_img[i]));
      end
    end
    checkOutput("sl_load_cnt",  32'(load_cnt),           32'd3);
    checkOutput("sl_trunc",     32'(load_trunc),         32'd0);
    checkOutput("sl_ram_pulse", 32'(ram_cnt - ram_base), 32'd1);
    checkOutput("sl_cpu_rst",   32'(cpu_rst),            32'd1);

    // Full load: 600 bytes offered, no ld_last; only 512 accepted
    wr_base = wr_addr_q.size();
    applyStimulus(OP_LOAD);
    checkOutput("fl_cnt_cleared", 32'(load_cnt), 32'd0);
    sent = 0;
    while (sent < 600 && ld_ready === 1'b1) begin
      ld_valid = 1'b1;
      ld_data  = 8'(sent) ^ 8'h5A;
      ld_last  = 1'b0;
      @(negedge clk);
      sent++;
    end
    ld_valid = 1'b0;
    @(negedge clk);
    checkOutput("fl_accepted", 32'(sent),       32'd512);
    checkOutput("fl_load_cnt", 32'(load_cnt),   32'd512);
    checkOutput("fl_trunc",    32'(load_trunc), 32'd1);
    checkOutput("fl_state",    32'(state),      32'(ST_HALTED));
    checkOutput("fl_wr_count", 32'(wr_addr_q.size() - wr_base), 32'd512);
    errs = 0;
    for (int k = 0; k < 512; k++) begin
      if (wr_addr_q.size() <= wr_base + k) errs++;
      else if (wr_addr_q[wr_base+k] !== 12'(k) || wr_data_q[wr_base+k] !== (8'(k) ^ 8'h5A)) errs++;
    end
    checkOutput("fl_writes_bad", 32'(errs), 32'd0);

    // Run, then HALT at an arbitrary phase
    applyStimulus(OP_RUN);
    checkOutput("run_state",   32'(state),   32'(ST_RUN));
    checkOutput("run_cpu_rst", 32'(cpu_rst), 32'd0);
    checkOutput("run_cpu_ce",  32'(cpu_ce),  32'd1);
    repeat (5) @(negedge clk);
    applyStimulus(OP_HALT);
    waitHalted("halt_wait", lat, last_sync);
    checkOutput("halt_after_sync", 32'(last_sync), 32'd1);
    checkOutput("halt_cpu_ce",     32'(cpu_ce),    32'd0);
    checkOutput("halt_phase",      32'(phase),     32'd0);
    checkOutput("halt_latency_ok", 32'(lat <= 9),  32'd1);

    // Three single steps: 8 enabled clocks and one SYNC each
    for (int s = 0; s < 3; s++) begin
      ce_base   = ce_cnt;
      sync_base = sync_cnt;
      applyStimulus(OP_STEP);
      waitHalted($sformatf("step%0d_wait", s), lat, last_sync);
      @(negedge clk);
      checkOutput($sformatf("step%0d_ce_clks", s), 32'(ce_cnt - ce_base),     32'd8);
      checkOutput($sformatf("step%0d_syncs", s),   32'(sync_cnt - sync_base), 32'd1);
    end

    // LOAD while running is dropped and flagged
    applyStimulus(OP_RUN);
    applyStimulus(OP_LOAD);
    checkOutput("bad_cmd_err",  32'(cmd_err),  32'd1);
    checkOutput("bad_state",    32'(state),    32'(ST_RUN));
    checkOutput("bad_cpu_ce",   32'(cpu_ce),   32'd1);
    checkOutput("bad_ld_ready", 32'(ld_ready), 32'd0);
    applyStimulus(OP_HALT);
    waitHalted("bad_halt_wait", lat, last_sync);

    // Reset asserted with a ROM write in flight
    applyStimulus(OP_LOAD);
    ld_valid = 1'b1;
    ld_data  = 8'hAA;
    @(negedge clk);
    checkOutput("mid_wen_inflight", 32'(rom_wen), 32'd1);
    ld_data = 8'hBB;
    rst     = 1'b0;
    #1;
    checkOutput("mid_wen",      32'(rom_wen),   32'd0);
    checkOutput("mid_ld_ready", 32'(ld_ready),  32'd0);
    checkOutput("mid_state",    32'(state),     32'(ST_RESET));
    checkOutput("mid_rom_rst",  32'(rom_rst),   32'd1);
    checkOutput("mid_cmd_err",  32'(cmd_err),   32'd0);
    checkOutput("mid_load_cnt", 32'(load_cnt),  32'd0);
    ld_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("mid_recovered", 32'(state), 32'(ST_HALTED));

    $display("[TB] %0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
